// File: rtl/mem_sp_arb_pkg.sv
// Shared types and constants for the two-requester single-port memory arbiter.
package mem_sp_arb_pkg;

  localparam int NUM_REQ        = 2;
  localparam int MAX_RD_LATENCY = 4;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_entry_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/mem_sp_arb_rdpipe.sv
// Read-tracking shift pipe: carries {valid,id} of each issued read for RD_LATENCY cycles.
module mem_sp_arb_rdpipe
  import mem_sp_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  rd_entry_t in_entry,
  output rd_entry_t out_entry
);

  // Out-of-range latencies are clamped so the pipe always has 1..MAX_RD_LATENCY stages.
  localparam int DEPTH = (RD_LATENCY < 1) ? 1 :
                         (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  rd_entry_t stage_reg [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign out_entry = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_sp_arb.sv
// Round-robin arbiter/sequencer for two masters sharing one single-port memory.
// Optional per-requester grant counters are enabled by defining MEM_SP_ARB_STATS_EN.
module mem_sp_arb
  import mem_sp_arb_pkg::*;
#(
  parameter  int MEM_DATAWIDTH = 128,
  parameter  int MEM_ADDRWIDTH = 14,
  parameter  int RD_LATENCY    = 1,
  localparam int BW            = (MEM_DATAWIDTH + 7) / 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*BW-1:0]              req_we,
  input  logic [NUM_REQ*MEM_ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*MEM_DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [MEM_DATAWIDTH-1:0]           rsp_rdata,
  output logic                               mem_en,
  output logic [BW-1:0]                      mem_we,
  output logic [MEM_ADDRWIDTH-1:0]           mem_addr,
  output logic [MEM_DATAWIDTH-1:0]           mem_din,
  input  logic [MEM_DATAWIDTH-1:0]           mem_dout
`ifdef MEM_SP_ARB_STATS_EN
  ,
  input  logic                               stat_clr,
  output logic [31:0]                        stat_grant0,
  output logic [31:0]                        stat_grant1
`endif
);

  req_id_t   last_grant_reg;
  req_id_t   gnt_id;
  logic      gnt_valid;
  rd_entry_t rd_in;
  rd_entry_t rd_out;

  // No grants while reset is held, so req_ready stays low during reset.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (reset) begin
      unique case (req_valid)
        2'b01:   begin gnt_valid = 1'b1; gnt_id = 1'b0;            end
        2'b10:   begin gnt_valid = 1'b1; gnt_id = 1'b1;            end
        2'b11:   begin gnt_valid = 1'b1; gnt_id = ~last_grant_reg; end
        default: ;
      endcase
    end
  end

  assign req_ready = gnt_valid ? id_onehot(gnt_id) : '0;

  assign mem_en   = gnt_valid;
  assign mem_we   = gnt_valid ? req_we[int'(gnt_id)*BW +: BW] : '0;
  assign mem_addr = req_addr[int'(gnt_id)*MEM_ADDRWIDTH +: MEM_ADDRWIDTH];
  assign mem_din  = req_wdata[int'(gnt_id)*MEM_DATAWIDTH +: MEM_DATAWIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         last_grant_reg <= 1'b1;
    else if (gnt_valid) last_grant_reg <= gnt_id;
  end

  // Only reads are tracked; writes are fire-and-forget.
  assign rd_in.valid = gnt_valid && (mem_we == '0);
  assign rd_in.id    = gnt_id;

  mem_sp_arb_rdpipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .in_entry  (rd_in),
    .out_entry (rd_out)
  );

  assign rsp_valid = rd_out.valid ? id_onehot(rd_out.id) : '0;
  assign rsp_rdata = mem_dout;

`ifdef MEM_SP_ARB_STATS_EN
  logic [31:0] stat_reg [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                 stat_reg[gi] <= '0;
      else if (stat_clr)                          stat_reg[gi] <= '0;
      else if (req_ready[gi] && stat_reg[gi] != '1) stat_reg[gi] <= stat_reg[gi] + 32'd1;
    end
  end

  assign stat_grant0 = stat_reg[0];
  assign stat_grant1 = stat_reg[1];
`endif

endmodule

// File: tb/tb_mem_sp_arb.sv
// Directed bench for mem_sp_arb: one instance at RD_LATENCY=1 and one at RD_LATENCY=3, each with its own memory model.
module tb_mem_sp_arb;

  localparam int DW = 128;
  localparam int AW = 14;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [2*BW-1:0] req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;

  logic [1:0]    d1_req_ready, d3_req_ready, d1_rsp_valid, d3_rsp_valid;
  logic [DW-1:0] d1_rsp_rdata, d3_rsp_rdata, d1_mem_din, d3_mem_din;
  logic          d1_mem_en, d3_mem_en;
  logic [BW-1:0] d1_mem_we, d3_mem_we;
  logic [AW-1:0] d1_mem_addr, d3_mem_addr;
  logic [DW-1:0] dout1, dout3;
`ifdef MEM_SP_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   d1_stat0, d1_stat1, d3_stat0, d3_stat1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [DW-1:0] A5   = {16{8'hA5}};
  localparam logic [DW-1:0] BEEF = 128'hDEAD_BEEF;

  always #5 clk = ~clk;

  mem_sp_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_rdata(d1_rsp_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_din(d1_mem_din),
    .mem_dout(dout1)
`ifdef MEM_SP_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grant0(d1_stat0), .stat_grant1(d1_stat1)
`endif
  );

  mem_sp_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d3_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_din(d3_mem_din),
    .mem_dout(dout3)
`ifdef MEM_SP_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grant0(d3_stat0), .stat_grant1(d3_stat1)
`endif
  );

  // Write-first memory models; address 0x10 is preloaded with A5 bytes.
  function automatic logic [DW-1:0] init_val(input logic [5:0] a);
    return (a == 6'h10) ? A5 : '0;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [BW-1:0] we,
                                          input logic [DW-1:0] din);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem3 [64];
  bit   [63:0]   wr1 = '0;
  bit   [63:0]   wr3 = '0;
  logic [DW-1:0] p3 [3];

  always @(posedge clk) begin : model1
    logic [DW-1:0] w;
    logic [5:0]    a;
    a = d1_mem_addr[5:0];
    w = wr1[a] ? mem1[a] : init_val(a);
    if (d1_mem_en) begin
      w = merge(w, d1_mem_we, d1_mem_din);
      mem1[a] <= w;
      wr1[a]  <= 1'b1;
    end
    dout1 <= w;
  end

  always @(posedge clk) begin : model3
    logic [DW-1:0] w;
    logic [5:0]    a;
    a = d3_mem_addr[5:0];
    w = wr3[a] ? mem3[a] : init_val(a);
    if (d3_mem_en) begin
      w = merge(w, d3_mem_we, d3_mem_din);
      mem3[a] <= w;
      wr3[a]  <= 1'b1;
    end
    p3[0] <= w;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout3 = p3[2];

  // Requesters left waiting must hold their command stable.
  logic [1:0]      prev_valid, prev_ready;
  logic [2*BW-1:0] prev_we;
  logic [2*AW-1:0] prev_addr;
  logic [2*DW-1:0] prev_wdata;

  always @(posedge clk) begin
    if (!reset) begin
      prev_valid <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (prev_valid[i] && !prev_ready[i] && req_valid[i]) begin
          n_cmp++;
          assert ({req_we[i*BW +: BW], req_addr[i*AW +: AW], req_wdata[i*DW +: DW]} ===
                  {prev_we[i*BW +: BW], prev_addr[i*AW +: AW], prev_wdata[i*DW +: DW]})
          else begin
            n_fail++;
            $error("FAIL hold_stable req%0d: command changed while waiting", i);
          end
        end
      end
      prev_valid <= req_valid;
      prev_ready <= d1_req_ready;
      prev_we    <= req_we;
      prev_addr  <= req_addr;
      prev_wdata <= req_wdata;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    req_we[r*BW +: BW]    = we;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = data;
  endtask

  logic [1:0] exp_cont [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp_sw1  [8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
  logic [1:0] exp_sw3  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef MEM_SP_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    req_valid = 2'b11; #1;
    check("rst_ready_l1", 128'(d1_req_ready), 128'(2'b00));
    check("rst_ready_l3", 128'(d3_req_ready), 128'(2'b00));
    check("rst_rsp_l1",   128'(d1_rsp_valid), 128'(2'b00));
    check("rst_rsp_l3",   128'(d3_rsp_valid), 128'(2'b00));
    @(negedge clk);
    req_valid = 2'b00;
    reset     = 1'b1;
`ifdef MEM_SP_ARB_STATS_EN
    #1;
    check("rst_stat0", 128'(d1_stat0), 128'(0));
    check("rst_stat1", 128'(d1_stat1), 128'(0));
`endif

    // Single read from requester 0
    @(negedge clk);
    set_req(0, '0, 14'h10, '0);
    req_valid = 2'b01; #1;
    check("rd_ready",   128'(d1_req_ready), 128'(2'b01));
    check("rd_mem_en",  128'(d1_mem_en),    128'(1'b1));
    check("rd_mem_we",  128'(d1_mem_we),    128'(16'h0000));
    check("rd_mem_addr",128'(d1_mem_addr),  128'(14'h10));

    // Response for the read, while requester 1 writes addr 5
    @(negedge clk);
    set_req(1, 16'h000F, 14'h5, BEEF);
    req_valid = 2'b10; #1;
    check("rd_rsp_valid", 128'(d1_rsp_valid), 128'(2'b01));
    check("rd_rsp_rdata", d1_rsp_rdata, A5);
    check("wr_ready",     128'(d1_req_ready), 128'(2'b10));
    check("wr_mem_we",    128'(d1_mem_we),    128'(16'h000F));
    check("wr_mem_din",   d1_mem_din, BEEF);

    @(negedge clk);
    set_req(1, '0, 14'h5, '0); #1;
    check("wr_no_rsp",  128'(d1_rsp_valid), 128'(2'b00));
    check("raw_ready",  128'(d1_req_ready), 128'(2'b10));
    check("raw_mem_we", 128'(d1_mem_we),    128'(16'h0000));

    @(negedge clk);
    req_valid = 2'b00; #1;
    check("raw_rsp_valid", 128'(d1_rsp_valid), 128'(2'b10));
    check("raw_rsp_rdata", d1_rsp_rdata, BEEF);
    check("idle_mem_en",   128'(d1_mem_en), 128'(1'b0));
    check("idle_mem_we",   128'(d1_mem_we), 128'(16'h0000));
    repeat (3) @(negedge clk);

    // Contention: last grant was requester 1, so requester 0 leads
    set_req(0, 16'hFFFF, 14'h20, 128'h1111);
    set_req(1, 16'hFFFF, 14'h21, 128'h2222);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("cont_ready_%0d", k), 128'(d1_req_ready), 128'(exp_cont[k]));
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Back-to-back reads alternating requesters, both latencies
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        set_req(k % 2, '0, (k % 2 == 1) ? 14'h5 : 14'h10, '0);
        req_valid = (k % 2 == 1) ? 2'b10 : 2'b01;
      end else begin
        req_valid = 2'b00;
      end
      #1;
      check($sformatf("sweep_l1_rsp_%0d", k), 128'(d1_rsp_valid), 128'(exp_sw1[k]));
      check($sformatf("sweep_l3_rsp_%0d", k), 128'(d3_rsp_valid), 128'(exp_sw3[k]));
      if (exp_sw1[k] != 2'b00)
        check($sformatf("sweep_l1_data_%0d", k), d1_rsp_rdata, (exp_sw1[k] == 2'b01) ? A5 : BEEF);
      if (exp_sw3[k] != 2'b00)
        check($sformatf("sweep_l3_data_%0d", k), d3_rsp_rdata, (exp_sw3[k] == 2'b01) ? A5 : BEEF);
      @(negedge clk);
    end

    // Reset one cycle after issuing a read
    set_req(0, '0, 14'h10, '0);
    req_valid = 2'b01;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b11; #1;
    check("midrst_ready_l1", 128'(d1_req_ready), 128'(2'b00));
    check("midrst_ready_l3", 128'(d3_req_ready), 128'(2'b00));
    @(negedge clk);
    set_req(0, 16'hFFFF, 14'h30, 128'h3);
    set_req(1, 16'hFFFF, 14'h31, 128'h4);
    reset = 1'b1; #1;
    check("postrst_grant_l1", 128'(d1_req_ready), 128'(2'b01));
    check("postrst_grant_l3", 128'(d3_req_ready), 128'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("postrst_rsp_l3_%0d", k), 128'(d3_rsp_valid), 128'(2'b00));
      check($sformatf("postrst_rsp_l1_%0d", k), 128'(d1_rsp_valid), 128'(2'b00));
      @(negedge clk);
    end

`ifdef MEM_SP_ARB_STATS_EN
    // Clear coinciding with a grant wins
    stat_clr  = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    stat_clr  = 1'b0;
    req_valid = 2'b00; #1;
    check("stat_clr_prec0", 128'(d1_stat0), 128'(0));
    check("stat_clr_prec1", 128'(d1_stat1), 128'(0));
    for (int k = 0; k < 10; k++) begin
      set_req(0, 16'hFFFF, 14'(14'h40 + k), 128'(k));
      req_valid = 2'b01;
      @(negedge clk);
    end
    for (int k = 0; k < 7; k++) begin
      set_req(1, 16'hFFFF, 14'(14'h40 + k), 128'(k));
      req_valid = 2'b10;
      @(negedge clk);
    end
    req_valid = 2'b00; #1;
    check("stat_grant0_l1", 128'(d1_stat0), 128'(10));
    check("stat_grant1_l1", 128'(d1_stat1), 128'(7));
    check("stat_grant0_l3", 128'(d3_stat0), 128'(10));
    check("stat_grant1_l3", 128'(d3_stat1), 128'(7));
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0; #1;
    check("stat_clr0", 128'(d1_stat0), 128'(0));
    check("stat_clr1", 128'(d1_stat1), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
